psram_multiport: RTL and testbench

Multi-port controller for the asynchronous cellular PSRAM on the `cram_if` bus, replacing the single read/single write port controller. It takes up to `NUM_PORTS` independent requesters and grants them round-robin. It adds per-byte write enables, a tagged per-port read return, and a guaranteed chip-enable recovery cycle between accesses. It sits between the core's memory clients and the top-level `cram_if` pins.

---
 rtl/psram_multiport_if.sv | 32 +++
 rtl/psram_multiport.sv | 152 +++++++++++++++
 tb/tb_psram_multiport.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psram_multiport_if.sv
// Pin-level bundle for the asynchronous cellular PSRAM: controls, upper
// address bits, and the split data_out/data_in view of the shared dq pins.
interface cram_if #(
    parameter int ADDRESS_BITS = 23,
    parameter int DATA_BITS    = 16
);
    logic                    clk;
    logic                    cre;
    logic                    adv_n;
    logic                    ce0_n;
    logic                    ce1_n;
    logic                    oe_n;
    logic                    we_n;
    logic                    lb_n;
    logic                    ub_n;
    logic [ADDRESS_BITS-18:0] a;
    logic [DATA_BITS-1:0]    data_out;
    logic                    dq_oe;
    logic [DATA_BITS-1:0]    data_in;

    modport master (
        output clk, cre, adv_n, ce0_n, ce1_n, oe_n, we_n, lb_n, ub_n,
        output a, data_out, dq_oe,
        input  data_in
    );

    modport slave (
        input  clk, cre, adv_n, ce0_n, ce1_n, oe_n, we_n, lb_n, ub_n,
        input  a, data_out, dq_oe,
        output data_in
    );
endinterface

// File: rtl/psram_multiport.sv
// Round-robin multi-port controller for async PSRAM: address-multiplexed
// access with byte lanes, tagged read return and one chip-enable recovery cycle.
module psram_multiport #(
    parameter int CLK_FREQ        = 40000000,
    parameter int ADDRESS_BITS    = 23,
    parameter int DATA_BITS       = 16,
    parameter int NUM_PORTS       = 2,
    parameter int RAM_CYCLE_NANOS = 72
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_PORTS-1:0]                     req_valid,
    output logic [NUM_PORTS-1:0]                     req_ready,
    input  logic [NUM_PORTS-1:0]                     req_write,
    input  logic [NUM_PORTS-1:0][ADDRESS_BITS-1:0]   req_address,
    input  logic [NUM_PORTS-1:0][DATA_BITS-1:0]      req_wr_data,
    input  logic [NUM_PORTS-1:0][1:0]                req_byte_en,
    output logic [NUM_PORTS-1:0]                     rd_valid,
    output logic [DATA_BITS-1:0]                     rd_data,
    cram_if.master                                   cram,
    inout  wire  [DATA_BITS-1:0]                     cram_dq
);
    localparam logic [63:0] CYC_RAW = (64'(RAM_CYCLE_NANOS) * 64'(CLK_FREQ)
                                       + 64'd999999999) / 64'd1000000000;
    localparam int N  = (CYC_RAW < 64'd3) ? 3 : int'(CYC_RAW);
    localparam int CW = $clog2(N);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [2:0] {IDLE, ADDR, HOLD, DATA, RECOVER} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [PW-1:0]           last_q, last_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0]    wdata_q, wdata_d;
    logic [1:0]              be_q, be_d;
    logic                    wr_q, wr_d;
    logic [DATA_BITS-1:0]    rd_data_q, rd_data_d;

    logic                    gnt_any;
    logic [PW-1:0]           gnt_idx;
    logic [PW-1:0]           cand;

    // Search starts just past the previous winner so every port gets a turn.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = PW'((int'(last_q) + i) % NUM_PORTS);
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && gnt_any) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        wr_d      = wr_q;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE: if (gnt_any) begin
                addr_d  = req_address[gnt_idx];
                wdata_d = req_wr_data[gnt_idx];
                be_d    = req_byte_en[gnt_idx];
                wr_d    = req_write[gnt_idx];
                last_d  = gnt_idx;
                state_d = ADDR;
            end
            ADDR: begin
                // Reads spend N-1 cycles in DATA, writes N-2 after HOLD.
                if (wr_q) begin
                    state_d = HOLD;
                    cnt_d   = CW'(N - 3);
                end else begin
                    state_d = DATA;
                    cnt_d   = CW'(N - 2);
                end
            end
            HOLD: state_d = DATA;
            DATA: begin
                if (cnt_q == '0) begin
                    state_d = RECOVER;
                    if (!wr_q) rd_data_d = cram.data_in;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= PW'(NUM_PORTS - 1);
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            wr_q      <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            wr_q      <= wr_d;
            rd_data_q <= rd_data_d;
        end
    end

    logic active, lanes_on, bank;
    assign active   = (state_q == ADDR) || (state_q == HOLD) || (state_q == DATA);
    assign lanes_on = wr_q ? ((state_q == HOLD) || (state_q == DATA)) : (state_q == DATA);
    assign bank     = addr_q[ADDRESS_BITS-1];

    always_comb begin
        rd_valid = '0;
        if (state_q == RECOVER && !wr_q) rd_valid[last_q] = 1'b1;
    end
    assign rd_data = rd_data_q;

    assign cram.clk      = 1'b0;
    assign cram.cre      = 1'b0;
    assign cram.ce0_n    = bank | ~active;
    assign cram.ce1_n    = ~bank | ~active;
    assign cram.adv_n    = (state_q != ADDR);
    assign cram.we_n     = ~(active & wr_q);
    assign cram.oe_n     = ~((state_q == DATA) & ~wr_q);
    assign cram.lb_n     = ~(lanes_on & (~wr_q | be_q[0]));
    assign cram.ub_n     = ~(lanes_on & (~wr_q | be_q[1]));
    assign cram.a        = addr_q[ADDRESS_BITS-2:16];
    // dq carries the low address through HOLD, then write data for writes.
    assign cram.dq_oe    = (state_q == ADDR) || (state_q == HOLD) || ((state_q == DATA) && wr_q);
    assign cram.data_out = (state_q == DATA) ? wdata_q : addr_q[DATA_BITS-1:0];
    assign cram_dq       = cram.dq_oe ? cram.data_out : 'z;
endmodule

// File: tb/tb_psram_multiport.sv
// Directed bench: instance A (2 ports, 40 MHz, N=3) against a small PSRAM
// model; instance B (3 ports, 100 MHz, N=8) for latency and arbitration order.
module tb_psram_multiport;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [1:0]        req_valid_a, req_ready_a, req_write_a, rd_valid_a;
    logic [1:0][22:0]  req_address_a;
    logic [1:0][15:0]  req_wr_data_a;
    logic [1:0][1:0]   req_byte_en_a;
    logic [15:0]       rd_data_a;
    wire  [15:0]       dq_a;
    cram_if #(.ADDRESS_BITS(23), .DATA_BITS(16)) cram_a();

    psram_multiport #(.CLK_FREQ(40000000), .NUM_PORTS(2)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write_a),
        .req_address(req_address_a), .req_wr_data(req_wr_data_a), .req_byte_en(req_byte_en_a),
        .rd_valid(rd_valid_a), .rd_data(rd_data_a), .cram(cram_a), .cram_dq(dq_a)
    );

    logic [2:0]        req_valid_b, req_ready_b, req_write_b, rd_valid_b;
    logic [2:0][22:0]  req_address_b;
    logic [2:0][15:0]  req_wr_data_b;
    logic [2:0][1:0]   req_byte_en_b;
    logic [15:0]       rd_data_b;
    wire  [15:0]       dq_b;
    cram_if #(.ADDRESS_BITS(23), .DATA_BITS(16)) cram_b();
    assign cram_b.data_in = 16'h5555;

    psram_multiport #(.CLK_FREQ(100000000), .NUM_PORTS(3)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
        .req_address(req_address_b), .req_wr_data(req_wr_data_b), .req_byte_en(req_byte_en_b),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .cram(cram_b), .cram_dq(dq_b)
    );

    // PSRAM model: latch address on ADV#, stage write lanes while WE# low,
    // commit on WE# rising; 256 words indexed by the low address byte.
    logic [15:0] mem [0:255];
    logic [22:0] lat = '0;
    logic [15:0] wdat = '0;
    logic        wlo = 1'b0, whi = 1'b0, we_prev = 1'b1;
    logic [15:0] din = '0;
    assign cram_a.data_in = din;

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                          input logic lo, input logic hi);
        return {hi ? nw[15:8] : old[15:8], lo ? nw[7:0] : old[7:0]};
    endfunction

    always @(posedge clk) begin
        if (!cram_a.adv_n) lat <= {cram_a.ce0_n, cram_a.a, dq_a};
        if (!cram_a.we_n && cram_a.adv_n) begin
            wdat <= dq_a;
            wlo  <= ~cram_a.lb_n;
            whi  <= ~cram_a.ub_n;
        end
        if (!we_prev && cram_a.we_n) mem[lat[7:0]] <= merge(mem[lat[7:0]], wdat, wlo, whi);
        we_prev <= cram_a.we_n;
        din     <= mem[lat[7:0]];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int p, input logic [22:0] addr, input logic [15:0] d,
                            input logic [1:0] be);
        int n;
        tick();
        req_write_a[p] = 1'b1; req_address_a[p] = addr;
        req_wr_data_a[p] = d; req_byte_en_a[p] = be; req_valid_a[p] = 1'b1;
        #1;
        n = 0;
        while (!req_ready_a[p] && n < 50) begin tick(); n++; end
        tests++;
        if (n >= 50) begin fails++; $display("FAIL write_grant_timeout port %0d", p); end
        tick();
        req_valid_a[p] = 1'b0;
        repeat (6) tick();
    endtask

    task automatic do_read(input int p, input logic [22:0] addr, output logic [15:0] d);
        int n;
        d = '0;
        tick();
        req_write_a[p] = 1'b0; req_address_a[p] = addr; req_valid_a[p] = 1'b1;
        #1;
        n = 0;
        while (!req_ready_a[p] && n < 50) begin tick(); n++; end
        tick();
        req_valid_a[p] = 1'b0;
        while (!rd_valid_a[p] && n < 50) begin tick(); n++; end
        tests++;
        if (n >= 50) begin fails++; $display("FAIL read_timeout port %0d", p); end
        d = rd_data_a;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        tests++;
        if (req_ready_a !== 2'b00 || rd_valid_a !== 2'b00 || rd_data_a !== 16'h0) begin
            fails++;
            $display("FAIL reset_outputs got ready=%b rd_valid=%b rd_data=%h want 0/0/0",
                     req_ready_a, rd_valid_a, rd_data_a);
        end
        tests++;
        if ({cram_a.ce0_n, cram_a.ce1_n, cram_a.we_n, cram_a.oe_n, cram_a.adv_n,
             cram_a.lb_n, cram_a.ub_n, cram_a.dq_oe} !== 8'b1111_1110) begin
            fails++;
            $display("FAIL reset_controls got ce0 %b ce1 %b we %b oe %b adv %b lb %b ub %b dq_oe %b want all 1, dq_oe 0",
                     cram_a.ce0_n, cram_a.ce1_n, cram_a.we_n, cram_a.oe_n, cram_a.adv_n,
                     cram_a.lb_n, cram_a.ub_n, cram_a.dq_oe);
        end
    endtask

    task automatic test_read();
        do_write(0, 23'h000123, 16'hBEEF, 2'b11);
        tick();
        req_write_a[0] = 1'b0; req_address_a[0] = 23'h000123; req_valid_a[0] = 1'b1;
        #1;
        tests++;
        if (req_ready_a !== 2'b01) begin fails++; $display("FAIL read_ready_c0 got %b want 01", req_ready_a); end
        tick();
        req_valid_a[0] = 1'b0;
        #1;
        tests++;
        if ({cram_a.ce0_n, cram_a.ce1_n, cram_a.adv_n, cram_a.oe_n, cram_a.we_n} !== 5'b01011
            || dq_a !== 16'h0123 || cram_a.dq_oe !== 1'b1) begin
            fails++;
            $display("FAIL read_c1 got ce0 %b ce1 %b adv %b oe %b we %b dq %h want 0 1 0 1 1 0123",
                     cram_a.ce0_n, cram_a.ce1_n, cram_a.adv_n, cram_a.oe_n, cram_a.we_n, dq_a);
        end
        tick();
        tests++;
        if ({cram_a.ce0_n, cram_a.adv_n, cram_a.oe_n, cram_a.lb_n, cram_a.ub_n, cram_a.dq_oe} !== 6'b010000) begin
            fails++;
            $display("FAIL read_c2 got ce0 %b adv %b oe %b lb %b ub %b dq_oe %b want 0 1 0 0 0 0",
                     cram_a.ce0_n, cram_a.adv_n, cram_a.oe_n, cram_a.lb_n, cram_a.ub_n, cram_a.dq_oe);
        end
        tick();
        tests++;
        if (cram_a.ce0_n !== 1'b0 || cram_a.oe_n !== 1'b0 || rd_valid_a !== 2'b00) begin
            fails++;
            $display("FAIL read_c3 got ce0 %b oe %b rd_valid %b want 0 0 00",
                     cram_a.ce0_n, cram_a.oe_n, rd_valid_a);
        end
        tick();
        tests++;
        if (rd_valid_a !== 2'b01 || rd_data_a !== 16'hBEEF || cram_a.ce0_n !== 1'b1 || cram_a.oe_n !== 1'b1) begin
            fails++;
            $display("FAIL read_c4 got rd_valid %b rd_data %h ce0 %b oe %b want 01 BEEF 1 1",
                     rd_valid_a, rd_data_a, cram_a.ce0_n, cram_a.oe_n);
        end
        tick();
        tests++;
        if (rd_valid_a !== 2'b00) begin fails++; $display("FAIL read_c5_pulse got %b want 00", rd_valid_a); end
    endtask

    task automatic test_write_lane();
        logic [15:0] d;
        do_write(0, 23'h400010, 16'h1111, 2'b11);
        tick();
        req_write_a[1] = 1'b1; req_address_a[1] = 23'h400010;
        req_wr_data_a[1] = 16'hA55A; req_byte_en_a[1] = 2'b01; req_valid_a[1] = 1'b1;
        #1;
        tests++;
        if (req_ready_a !== 2'b10) begin fails++; $display("FAIL write_ready_c0 got %b want 10", req_ready_a); end
        tick();
        req_valid_a[1] = 1'b0;
        #1;
        tests++;
        if ({cram_a.ce1_n, cram_a.ce0_n, cram_a.ub_n, cram_a.lb_n, cram_a.we_n, cram_a.adv_n} !== 6'b011100) begin
            fails++;
            $display("FAIL write_c1 got ce1 %b ce0 %b ub %b lb %b we %b adv %b want 0 1 1 1 0 0",
                     cram_a.ce1_n, cram_a.ce0_n, cram_a.ub_n, cram_a.lb_n, cram_a.we_n, cram_a.adv_n);
        end
        tick();
        tests++;
        if ({cram_a.ce1_n, cram_a.ce0_n, cram_a.ub_n, cram_a.lb_n, cram_a.we_n} !== 5'b01100) begin
            fails++;
            $display("FAIL write_c2 got ce1 %b ce0 %b ub %b lb %b we %b want 0 1 1 0 0",
                     cram_a.ce1_n, cram_a.ce0_n, cram_a.ub_n, cram_a.lb_n, cram_a.we_n);
        end
        tick();
        tests++;
        if (cram_a.ub_n !== 1'b1 || cram_a.lb_n !== 1'b0 || dq_a !== 16'hA55A || cram_a.we_n !== 1'b0) begin
            fails++;
            $display("FAIL write_c3 got ub %b lb %b we %b dq %h want 1 0 0 A55A",
                     cram_a.ub_n, cram_a.lb_n, cram_a.we_n, dq_a);
        end
        tick();
        tests++;
        if (rd_valid_a !== 2'b00 || cram_a.ce1_n !== 1'b1 || cram_a.we_n !== 1'b1 || cram_a.ub_n !== 1'b1) begin
            fails++;
            $display("FAIL write_c4 got rd_valid %b ce1 %b we %b ub %b want 00 1 1 1",
                     rd_valid_a, cram_a.ce1_n, cram_a.we_n, cram_a.ub_n);
        end
        repeat (2) tick();
        do_read(0, 23'h400010, d);
        tests++;
        if (d !== 16'h115A) begin fails++; $display("FAIL write_lane_readback got %h want 115A", d); end
    endtask

    task automatic test_byte_en_zero();
        logic [15:0] d;
        logic        lanes_seen;
        do_write(0, 23'h000040, 16'h1234, 2'b11);
        tick();
        req_write_a[0] = 1'b1; req_address_a[0] = 23'h000040;
        req_wr_data_a[0] = 16'hFFFF; req_byte_en_a[0] = 2'b00; req_valid_a[0] = 1'b1;
        #1;
        tests++;
        if (req_ready_a !== 2'b01) begin fails++; $display("FAIL be0_ready got %b want 01", req_ready_a); end
        tick();
        req_valid_a[0] = 1'b0;
        lanes_seen = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (!cram_a.lb_n || !cram_a.ub_n) lanes_seen = 1'b1;
            tick();
        end
        tests++;
        if (lanes_seen !== 1'b0) begin fails++; $display("FAIL be0_lanes got lane strobe low want both high"); end
        repeat (2) tick();
        do_read(0, 23'h000040, d);
        tests++;
        if (d !== 16'h1234) begin fails++; $display("FAIL be0_readback got %h want 1234", d); end
    endtask

    task automatic test_round_robin();
        int gp[4];
        int gc[4];
        int ng, cyc;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        req_write_a = 2'b00;
        req_address_a[0] = 23'h000123; req_address_a[1] = 23'h000040;
        req_valid_a = 2'b11;
        #1;
        ng = 0; cyc = 0;
        while (ng < 4 && cyc < 60) begin
            if (req_ready_a == 2'b01 || req_ready_a == 2'b10) begin
                gp[ng] = (req_ready_a == 2'b10) ? 1 : 0;
                gc[ng] = cyc;
                ng++;
            end
            tick();
            cyc++;
        end
        req_valid_a = 2'b00;
        repeat (6) tick();
        tests++;
        if (ng != 4) begin
            fails++;
            $display("FAIL rr_grant_count got %0d want 4", ng);
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (gp[k] != (k % 2)) begin fails++; $display("FAIL rr_order[%0d] got port %0d want %0d", k, gp[k], k % 2); end
            end
            for (int k = 1; k < 4; k++) begin
                tests++;
                if (gc[k] - gc[k-1] != 5) begin fails++; $display("FAIL rr_gap[%0d] got %0d want 5", k, gc[k] - gc[k-1]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        tick();
        req_write_a[0] = 1'b0; req_address_a[0] = 23'h000123; req_valid_a[0] = 1'b1;
        tick();
        req_valid_a[0] = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tests++;
        if ({cram_a.ce0_n, cram_a.ce1_n, cram_a.we_n, cram_a.oe_n, cram_a.adv_n, rd_valid_a} !== 7'b1111100) begin
            fails++;
            $display("FAIL reset_mid_controls got ce0 %b ce1 %b we %b oe %b adv %b rd_valid %b want 1 1 1 1 1 00",
                     cram_a.ce0_n, cram_a.ce1_n, cram_a.we_n, cram_a.oe_n, cram_a.adv_n, rd_valid_a);
        end
        reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (rd_valid_a !== 2'b00) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin fails++; $display("FAIL reset_mid_rd_valid got pulse want none"); end
        req_address_a[1] = 23'h000040; req_write_a = 2'b00;
        req_valid_a = 2'b11;
        #1;
        tests++;
        if (req_ready_a !== 2'b01) begin fails++; $display("FAIL reset_mid_first_grant got %b want 01", req_ready_a); end
        tick();
        req_valid_a = 2'b00;
        repeat (6) tick();
    endtask

    task automatic test_wide();
        int n;
        int gp[3];
        int gc[3];
        int ng, cyc;
        tick();
        req_write_b = 3'b000; req_address_b[0] = 23'h000011;
        req_address_b[1] = 23'h000022; req_address_b[2] = 23'h400033;
        req_valid_b = 3'b001;
        #1;
        tests++;
        if (req_ready_b !== 3'b001) begin fails++; $display("FAIL wide_ready got %b want 001", req_ready_b); end
        tick();
        req_valid_b = 3'b000;
        n = 1;
        while (!rd_valid_b[0] && n < 20) begin tick(); n++; end
        tests++;
        if (n != 9) begin fails++; $display("FAIL wide_read_latency got %0d want 9", n); end
        tests++;
        if (rd_data_b !== 16'h5555) begin fails++; $display("FAIL wide_rd_data got %h want 5555", rd_data_b); end
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        req_valid_b = 3'b111;
        #1;
        ng = 0; cyc = 0;
        while (ng < 3 && cyc < 80) begin
            if (req_ready_b != 3'b000) begin
                gp[ng] = req_ready_b[2] ? 2 : (req_ready_b[1] ? 1 : 0);
                gc[ng] = cyc;
                ng++;
            end
            tick();
            cyc++;
        end
        req_valid_b = 3'b000;
        repeat (12) tick();
        tests++;
        if (ng != 3) begin
            fails++;
            $display("FAIL wide_grant_count got %0d want 3", ng);
        end else begin
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (gp[k] != k) begin fails++; $display("FAIL wide_order[%0d] got port %0d want %0d", k, gp[k], k); end
            end
            for (int k = 1; k < 3; k++) begin
                tests++;
                if (gc[k] - gc[k-1] != 10) begin fails++; $display("FAIL wide_gap[%0d] got %0d want 10", k, gc[k] - gc[k-1]); end
            end
        end
    endtask

    initial begin
        req_valid_a = '0; req_write_a = '0; req_address_a = '0; req_wr_data_a = '0; req_byte_en_a = '0;
        req_valid_b = '0; req_write_b = '0; req_address_b = '0; req_wr_data_b = '0; req_byte_en_b = '0;
        test_reset();
        test_read();
        test_write_lane();
        test_byte_en_zero();
        test_round_robin();
        test_reset_mid();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
